// File: rtl/t01_score_keeper.sv
// Score accumulator with saturation and double-dabble binary-to-BCD conversion.
// Publishes registered hundreds/tens/ones digits for the score renderer.
module t01_score_keeper #(
   parameter logic [9:0] P1        = 10'd1,
   parameter logic [9:0] P2        = 10'd3,
   parameter logic [9:0] P3        = 10'd5,
   parameter logic [9:0] P4        = 10'd8,
   parameter logic [9:0] MAX_SCORE = 10'd999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_score,
   input  logic       lines_valid,
   input  logic [2:0] lines,
   output logic       lines_ready,
   output logic [9:0] score,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       bcd_valid
);

   typedef enum logic [1:0] {IDLE, ADD, CONV} state_t;

   state_t      state, state_nxt;
   logic [9:0]  pts, pts_sel;
   logic        lines_legal;
   logic        accept;
   logic [10:0] sum;
   logic [9:0]  score_sat;
   logic [21:0] bcd_sr, bcd_adj, bcd_shift;
   logic [3:0]  iter;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   always_comb begin
      pts_sel     = '0;
      lines_legal = 1'b1;
      case (lines)
         3'd1:    pts_sel = P1;
         3'd2:    pts_sel = P2;
         3'd3:    pts_sel = P3;
         3'd4:    pts_sel = P4;
         default: lines_legal = 1'b0;
      endcase
   end

   assign lines_ready = (state == IDLE);
   assign accept      = lines_valid && lines_ready && lines_legal;

   // 11-bit sum so score + pts cannot wrap before the saturation compare
   assign sum       = {1'b0, score} + {1'b0, pts};
   assign score_sat = (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[9:0];

   assign bcd_adj   = {add3(bcd_sr[21:18]), add3(bcd_sr[17:14]), add3(bcd_sr[13:10]), bcd_sr[9:0]};
   assign bcd_shift = bcd_adj << 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear_score) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = ADD;
            ADD:     state_nxt = CONV;
            CONV:    if (iter == 4'd9) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pts       <= '0;
         score     <= '0;
         bcd_sr    <= '0;
         iter      <= '0;
         hundreds  <= '0;
         tens      <= '0;
         ones      <= '0;
         bcd_valid <= 1'b1;
      end else if (clear_score) begin
         score     <= '0;
         hundreds  <= '0;
         tens      <= '0;
         ones      <= '0;
         bcd_valid <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  pts       <= pts_sel;
                  bcd_valid <= 1'b0;
               end
            end
            ADD: begin
               score  <= score_sat;
               bcd_sr <= {12'd0, score_sat};
               iter   <= '0;
            end
            CONV: begin
               bcd_sr <= bcd_shift;
               iter   <= iter + 4'd1;
               if (iter == 4'd9) begin
                  hundreds  <= bcd_shift[21:18];
                  tens      <= bcd_shift[17:14];
                  ones      <= bcd_shift[13:10];
                  bcd_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_t01_score_keeper.sv
// Randomized and directed bench for t01_score_keeper against an event-timed
// reference model (accept edge, score one edge later, digits eleven edges later).
module tb_t01_score_keeper;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear_score;
   logic       lines_valid;
   logic [2:0] lines;
   logic       lines_ready;
   logic [9:0] score;
   logic [3:0] hundreds, tens, ones;
   logic       bcd_valid;

   localparam int MAXS = 999;

   t01_score_keeper #(
      .P1(10'd1), .P2(10'd3), .P3(10'd5), .P4(10'd8), .MAX_SCORE(10'd999)
   ) dut (
      .clk(clk), .rst(rst), .clear_score(clear_score), .lines_valid(lines_valid),
      .lines(lines), .lines_ready(lines_ready), .score(score), .hundreds(hundreds),
      .tens(tens), .ones(ones), .bcd_valid(bcd_valid)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // reference model state
   int m_score, m_h, m_t, m_o, m_valid;
   int pend, acc_e, pend_score;
   int e, next_acc;

   task automatic check_val(input string tag, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, e);
   endtask

   task automatic check_all();
      check_val("score", int'(score), m_score);
      check_val("hundreds", int'(hundreds), m_h);
      check_val("tens", int'(tens), m_t);
      check_val("ones", int'(ones), m_o);
      check_val("bcd_valid", int'(bcd_valid), m_valid);
      check_val("lines_ready", int'(lines_ready), int'(e >= next_acc));
   endtask

   task automatic model_reset();
      m_score = 0; m_h = 0; m_t = 0; m_o = 0; m_valid = 1;
      pend = 0; acc_e = 0; pend_score = 0; next_acc = 0;
   endtask

   function automatic int pts_of(input int l);
      case (l)
         1: return 1;
         2: return 3;
         3: return 5;
         default: return 8;
      endcase
   endfunction

   // One clock edge: drive inputs, predict, clock, check.
   task automatic step(input logic v, input logic [2:0] l, input logic c);
      int acc;
      lines_valid = v; lines = l; clear_score = c;
      acc = int'(v && (e >= next_acc) && !c && l >= 3'd1 && l <= 3'd4);
      @(posedge clk); #1;
      if (c) begin
         m_score = 0; m_h = 0; m_t = 0; m_o = 0; m_valid = 1;
         pend = 0; next_acc = e + 1;
      end else begin
         if (acc != 0) begin
            pend = 1; acc_e = e; next_acc = e + 12; m_valid = 0;
            pend_score = m_score + pts_of(int'(l));
            if (pend_score > MAXS) pend_score = MAXS;
         end
         if (pend != 0 && e == acc_e + 1) m_score = pend_score;
         if (pend != 0 && e == acc_e + 11) begin
            m_h = m_score / 100; m_t = (m_score / 10) % 10; m_o = m_score % 10;
            m_valid = 1; pend = 0;
         end
      end
      e++;
      check_all();
   endtask

   task automatic send(input logic [2:0] l);
      step(1'b1, l, 1'b0);
      repeat (11) step(1'b0, 3'd0, 1'b0);
   endtask

   initial begin
      e = 0;
      model_reset();
      rst = 1'b1; clear_score = 1'b0; lines_valid = 1'b0; lines = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;

      // single quad event
      send(3'd4);
      // ignored lines values in IDLE
      step(1'b1, 3'd0, 1'b0);
      step(1'b1, 3'd6, 1'b0);
      step(1'b1, 3'd7, 1'b0);
      // valid held through a conversion: one accept, then one more at N+12
      repeat (13) step(1'b1, 3'd2, 1'b0);
      repeat (12) step(1'b0, 3'd0, 1'b0);

      // build up to 123 then clear on the 5th CONV cycle with a concurrent event
      step(1'b0, 3'd0, 1'b1);
      repeat (40) send(3'd2);
      step(1'b1, 3'd2, 1'b0);
      repeat (5) step(1'b0, 3'd0, 1'b0);
      step(1'b1, 3'd4, 1'b1);
      repeat (3) step(1'b0, 3'd0, 1'b0);

      // asynchronous reset in the middle of a conversion
      step(1'b1, 3'd3, 1'b0);
      repeat (4) step(1'b0, 3'd0, 1'b0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b0;

      // conversion sweep 1..999 via single-line events, then saturation
      repeat (1000) send(3'd1);

      // saturation from 992
      step(1'b0, 3'd0, 1'b1);
      repeat (124) send(3'd4);
      send(3'd3);
      send(3'd4);
      send(3'd4);

      // randomized traffic
      step(1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 2000; i++)
         step(1'(($urandom % 3) != 0), 3'($urandom % 8), 1'(($urandom % 300) == 0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/t01_score_keeper.md
# t01_score_keeper

Sequential score accumulator and binary-to-BCD converter that produces the score shown by the on-screen score renderer. It accepts line-clear events from the game controller, adds a per-event point value with saturation at 999, then runs a 10-iteration shift-and-add-3 (double-dabble) conversion. The result is published as registered hundreds/tens/ones digits, so the display path needs no dividers.

## Interface
- P1, default 10'd1: points for clearing 1 line
- P2, default 10'd3: points for clearing 2 lines
- P3, default 10'd5: points for clearing 3 lines
- P4, default 10'd8: points for clearing 4 lines
- MAX_SCORE, default 10'd999: saturation ceiling; must be ≤ 999

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear_score  in  1  synchronous clear for a new game
- lines_valid  in  1  line-clear event strobe
- lines  in  3  number of lines cleared with the event (1..4 meaningful)
- lines_ready  out  1  high when an event can be accepted
- score  out  10  binary score, registered
- hundreds  out  4  BCD hundreds digit, registered
- tens  out  4  BCD tens digit, registered
- ones  out  4  BCD ones digit, registered
- bcd_valid  out  1  digits match score; registered

## Operation
- FSM states:
  - IDLE: lines_ready = 1.
  - ADD: one cycle.
  - CONV: 10 cycles, with a 4-bit iteration counter.
- An event is accepted when lines_valid && lines_ready at a rising edge.
- Lines-to-points mapping: 1→P1, 2→P2, 3→P3, 4→P4.
- Accepted event with lines of 0 or 5..7:
  - The event is ignored and the FSM stays in IDLE.
  - score, the digits and bcd_valid are unchanged.
- Accepted legal event (lines 1..4):
  - The points value is latched, state goes to ADD, bcd_valid goes to 0.
- ADD:
  - The sum is computed in 11 bits: score_next = min(score + pts, MAX_SCORE).
  - score register, BCD shift register ({12'd0, score_next}) and counter=0 are loaded.
  - State goes to CONV.
- CONV, each cycle:
  - Every BCD nibble ≥ 5 gets +3.
  - The 22-bit register then shifts left by 1, and the counter increments.
  - On the 10th shift (counter==9), hundreds/tens/ones load from the shifted BCD nibbles.
  - On that same edge bcd_valid goes to 1 and state goes to IDLE.
- During ADD and CONV:
  - The digits hold their previous values.
  - lines_valid is ignored; the event is not queued, and the producer must wait for lines_ready.
- clear_score has priority over everything except rst:
  - Next edge, from any state: score=0, digits=0, bcd_valid=1, state=IDLE.
  - Any in-flight conversion and any simultaneous event are dropped.
- At saturation, further legal events still run a conversion; score stays at MAX_SCORE.

## Timing
- Reset values (rst asserted, asynchronous): state IDLE, score=0, hundreds=tens=ones=0, bcd_valid=1.
- lines_ready = (state == IDLE), combinational from state; it goes to 0 the cycle after acceptance.
- Event accepted at edge N:
  - edge N+1: score updated.
  - edges N+2..N+11: the 10 CONV iterations.
  - edge N+11: digits updated and bcd_valid=1.
- Total latency from event to digits is 11 cycles; the next event can be accepted at edge N+12.
- lines_ready returns to 1 after edge N+11. A lines_valid held high from then on is accepted at edge N+12, so back-to-back events are accepted every 12 cycles.
- rst during CONV: immediate return to reset values, independent of clk.
- Outputs are all registered except lines_ready, so the display path sees no glitches.

## Test plan
- Reset: assert rst mid-cycle → all outputs immediately at reset values; lines_ready=1.
- Single event: lines=4 pulse at edge N → score=8 at N+1; bcd_valid=0 for N+1..N+10; digits 0/0/8 with bcd_valid=1 at N+11.
- Saturation: 124 quad events (score 992), then lines=3 → 997 (digits 9/9/7), then lines=4 → score=999, digits 9/9/9, no wrap.
- Illegal/ignored events:
  - lines=0 and lines=6 in IDLE → score unchanged, bcd_valid stays 1, lines_ready stays 1.
  - lines_valid held during CONV → ignored until lines_ready=1, then exactly one accept.
- Clear mid-conversion: score 123 converting, clear_score at 5th CONV cycle → next edge score=0, digits 0/0/0, bcd_valid=1, IDLE; a simultaneous lines_valid is dropped.
- Conversion sweep: drive each score 0..999 reachable via P1 events, compare the digits against score/100, (score/10)%10 and score%10 on every bcd_valid rising edge.
